// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive buffer.
// Covers the FSM state type, bus addresses and status bit positions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [1:0] ADDR_RXDATA = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  localparam int ST_OVR  = 0;
  localparam int ST_FERR = 1;
  localparam int ST_PERR = 2;
  localparam int ST_CNT  = 4;

  function automatic logic [7:0] pack_status(
    input logic [3:0] cnt,
    input logic       perr,
    input logic       ferr,
    input logic       ovr
  );
    logic [7:0] s;
    s = '0;
    s[ST_CNT+:4] = cnt;
    s[ST_PERR]   = perr;
    s[ST_FERR]   = ferr;
    s[ST_OVR]    = ovr;
    return s;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Synchronous receive FIFO with registered count.
// A pop and a push in one cycle both succeed, even when full.
module rx_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with FIFO and memory-mapped
// data/status registers on a shared tri-state bus.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       RxD,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       rx_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B  = BW'(DATA_W - 1);
  localparam logic          ODD     = 1'(PARITY_ODD);

  logic rx_meta_q, rx_sync_q, rxd;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rxd = rx_sync_q;

  rx_state_t         state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_pend_q, perr_pend_d;
  logic              push, set_ferr, set_perr;
  logic              at_half, at_full;

  assign at_half = (tick_q == HALF_M1);
  assign at_full = (tick_q == FULL_M1);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    push        = 1'b0;
    set_ferr    = 1'b0;
    set_perr    = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (!at_half) begin
            tick_d = tick_q + 1'b1;
          end else if (!rxd) begin
            tick_d      = '0;
            bit_d       = '0;
            perr_pend_d = 1'b0;
            state_d     = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (!at_full) begin
            tick_d = tick_q + 1'b1;
          end else begin
            tick_d = '0;
            if (MSB_FIRST != 0)
              shift_d = {shift_q[DATA_W-2:0], rxd};
            else
              shift_d = {rxd, shift_q[DATA_W-1:1]};
            if (bit_q == LAST_B)
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            else
              bit_d = bit_q + 1'b1;
          end
        end
        PARITY: begin
          if (!at_full) begin
            tick_d = tick_q + 1'b1;
          end else begin
            tick_d = '0;
            if (rxd != ((^shift_q) ^ ODD)) perr_pend_d = 1'b1;
            state_d = STOP;
          end
        end
        STOP: begin
          if (!at_full) begin
            tick_d = tick_q + 1'b1;
          end else begin
            tick_d = '0;
            if (rxd) begin
              push     = 1'b1;
              set_perr = perr_pend_q;
              state_d  = IDLE;
            end else begin
              set_ferr = 1'b1;
              state_d  = BREAK;
            end
          end
        end
        BREAK: begin
          if (rxd) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
    end
  end

  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              rd_data, rd_stat;

  assign rd_data = iocs & iorw & (ioaddr == ADDR_RXDATA);
  assign rd_stat = iocs & iorw & (ioaddr == ADDR_STATUS);

  rx_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (rd_data),
    .din_i   (shift_q),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  logic ovr_q, ovr_d;
  logic ferr_q, ferr_d;
  logic perr_q, perr_d;
  logic rda_q, rda_d;
  logic set_ovr;

  // A full FIFO only drops the push when no pop frees a slot.
  assign set_ovr = push & full & ~rd_data;

  always_comb begin
    ovr_d  = set_ovr  | (ovr_q  & ~rd_stat);
    ferr_d = set_ferr | (ferr_q & ~rd_stat);
    perr_d = set_perr | (perr_q & ~rd_stat);
    rda_d  = push
           | (count > CW'(1))
           | ((count == CW'(1)) & ~rd_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      rda_q  <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
      rda_q  <= rda_d;
    end
  end

  assign rda    = rda_q;
  assign rx_err = ovr_q | ferr_q | perr_q;

  logic [31:0] cnt_w;
  logic [3:0]  cnt_sat;
  logic [7:0]  bus_val;

  always_comb begin
    cnt_w   = 32'(count);
    cnt_sat = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];
    bus_val = 8'h00;
    unique case (1'b1)
      rd_data: bus_val = empty ? 8'h00 : 8'(head);
      rd_stat: bus_val = pack_status(cnt_sat, perr_q,
                                     ferr_q, ovr_q);
      default: bus_val = 8'h00;
    endcase
  end

  assign databus = (rd_data | rd_stat) ? bus_val : 8'bz;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table,
// directed corner cases and a queue-based random model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rxd_tb = 1'b1;
  logic       sel = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;

  logic rxd0, rxd1, iocs0, iocs1;
  wire  [7:0] db0, db1;
  logic [7:0] dbus;
  logic rda0, rda1, err0, err1, rda_w, err_w;

  assign rxd0  = sel ? 1'b1 : rxd_tb;
  assign rxd1  = sel ? rxd_tb : 1'b1;
  assign iocs0 = iocs & ~sel;
  assign iocs1 = iocs & sel;
  assign dbus  = sel ? db1 : db0;
  assign rda_w = sel ? rda1 : rda0;
  assign err_w = sel ? err1 : err0;

  uart_rx_fifo u_dut (
    .clk(clk), .rst(rst), .enable(enable), .RxD(rxd0),
    .iocs(iocs0), .iorw(iorw), .ioaddr(ioaddr),
    .databus(db0), .rda(rda0), .rx_err(err0)
  );

  uart_rx_fifo #(.DATA_W(7), .PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst), .enable(enable), .RxD(rxd1),
    .iocs(iocs1), .iorw(iorw), .ioaddr(ioaddr),
    .databus(db1), .rda(rda1), .rx_err(err1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  logic m_ovr, m_ferr, m_perr;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic b);
    @(negedge clk);
    rxd_tb = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 v = dbus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
  endtask

  task automatic wr_or_unmapped(input logic kind);
    @(negedge clk);
    iocs = 1'b1;
    iorw = kind;
    ioaddr = kind ? 2'b10 : 2'b00;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rxd_tb = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    repeat (3) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] ch,
                            input logic stp,
                            input logic pflip,
                            input logic rd_stop,
                            input int hold_lo,
                            output logic [7:0] rdv);
    int w, p, nb, stop_t;
    logic [11:0] bits;
    logic par;
    w = sel ? 7 : 8;
    p = sel ? 1 : 0;
    nb = w + p + 2;
    stop_t = 9 + 16 * (nb - 1);
    bits = '0;
    par = 1'b0;
    for (int i = 0; i < w; i++) begin
      bits[1+i] = ch[w-1-i];
      par ^= ch[i];
    end
    if (p != 0) bits[1+w] = par ^ pflip;
    bits[nb-1] = stp;
    rdv = 8'h00;
    for (int t = 0; t < 16 * nb; t++) begin
      if (rd_stop && t == stop_t) begin
        @(negedge clk);
        rxd_tb = bits[t/16];
        enable = 1'b1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        #1 rdv = dbus;
        @(negedge clk);
        enable = 1'b0;
        iocs = 1'b0; iorw = 1'b0;
      end else begin
        tick(bits[t/16]);
      end
    end
    repeat (hold_lo) tick(1'b0);
    repeat (3) tick(1'b1);
  endtask

  task automatic send(input logic [7:0] ch, input logic stp);
    logic [7:0] d;
    send_frame(ch, stp, 1'b0, 1'b0, 0, d);
  endtask

  function automatic logic [7:0] model_stat();
    return {4'(mq.size()), 1'b0, m_perr, m_ferr, m_ovr};
  endfunction

  typedef struct {
    logic [7:0] ch;
    logic       stp;
    logic       e_rda;
    logic       e_err;
    logic [7:0] e_data;
    logic [7:0] e_stat;
  } vec_t;

  vec_t vt[6];

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v, e;
    int op;

    vt[0] = '{8'h68, 1'b1, 1'b1, 1'b0, 8'h68, 8'h00};
    vt[1] = '{8'h42, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02};
    vt[2] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 8'h00};
    vt[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00};
    vt[5] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02};

    do_reset();
    chk("reset_rda", rda_w, 1'b0);
    chk("reset_err", err_w, 1'b0);
    rd(2'b01, v); chk("reset_stat", v, 8'h00);
    rd(2'b00, v); chk("reset_empty_rd", v, 8'h00);

    send(8'h68, 1'b1);
    chk("t1_rda_up", rda_w, 1'b1);
    rd(2'b00, v); chk("t1_data", v, 8'h68);
    chk("t1_rda_down", rda_w, 1'b0);
    rd(2'b01, v); chk("t1_stat", v, 8'h00);

    for (int i = 0; i < 6; i++) begin
      send(vt[i].ch, vt[i].stp);
      chk($sformatf("vec%0d_rda", i), rda_w, vt[i].e_rda);
      chk($sformatf("vec%0d_err", i), err_w, vt[i].e_err);
      if (vt[i].e_rda) begin
        rd(2'b00, v);
        chk($sformatf("vec%0d_data", i), v, vt[i].e_data);
      end
      rd(2'b01, v);
      chk($sformatf("vec%0d_stat", i), v, vt[i].e_stat);
    end

    do_reset();
    send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'h81, 1'b1);
    send(8'h55, 1'b1); send(8'h3C, 1'b1);
    chk("t2_err", err_w, 1'b1);
    rd(2'b00, v); chk("t2_d0", v, 8'hAA);
    chk("t2_rda0", rda_w, 1'b1);
    rd(2'b00, v); chk("t2_d1", v, 8'hBB);
    chk("t2_rda1", rda_w, 1'b1);
    rd(2'b00, v); chk("t2_d2", v, 8'h81);
    chk("t2_rda2", rda_w, 1'b1);
    rd(2'b00, v); chk("t2_d3", v, 8'h55);
    chk("t2_rda3", rda_w, 1'b0);
    rd(2'b00, v); chk("t2_no3c", v, 8'h00);
    rd(2'b01, v); chk("t2_stat_ovr", v, 8'h01);
    rd(2'b01, v); chk("t2_stat_clr", v, 8'h00);

    repeat (4) tick(1'b0);
    repeat (20) tick(1'b1);
    chk("t3_rda", rda_w, 1'b0);
    rd(2'b01, v); chk("t3_stat", v, 8'h00);
    send(8'h81, 1'b1);
    rd(2'b00, v); chk("t3_data", v, 8'h81);

    send_frame(8'h42, 1'b0, 1'b0, 1'b0, 60, v);
    chk("t4_rda", rda_w, 1'b0);
    chk("t4_err", err_w, 1'b1);
    rd(2'b01, v); chk("t4_stat", v, 8'h02);
    rd(2'b01, v); chk("t4_stat_clr", v, 8'h00);
    chk("t4_err_clr", err_w, 1'b0);
    send(8'h24, 1'b1);
    rd(2'b00, v); chk("t4_after", v, 8'h24);

    sel = 1'b1;
    do_reset();
    send_frame(8'h35, 1'b1, 1'b1, 1'b0, 0, v);
    rd(2'b00, v); chk("t5_bad_data", v, 8'h35);
    rd(2'b01, v); chk("t5_bad_stat", v, 8'h04);
    send_frame(8'h35, 1'b1, 1'b0, 1'b0, 0, v);
    rd(2'b00, v); chk("t5_ok_data", v, 8'h35);
    rd(2'b01, v); chk("t5_ok_stat", v, 8'h00);
    sel = 1'b0;

    do_reset();
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    send(8'h33, 1'b1); send(8'h44, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 0, v);
    chk("t6_head", v, 8'h11);
    rd(2'b01, v); chk("t6_stat", v, 8'h40);
    rd(2'b00, v); chk("t6_d1", v, 8'h22);
    rd(2'b00, v); chk("t6_d2", v, 8'h33);
    rd(2'b00, v); chk("t6_d3", v, 8'h44);
    rd(2'b00, v); chk("t6_d4", v, 8'h55);
    rd(2'b01, v); chk("t6_stat_end", v, 8'h00);

    send(8'h66, 1'b1); send(8'h77, 1'b1);
    repeat (40) tick(1'b0);
    @(negedge clk); rst = 1'b1; rxd_tb = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk("t6_rst_rda", rda_w, 1'b0);
    repeat (4) tick(1'b1);
    rd(2'b01, v); chk("t6_rst_stat", v, 8'h00);
    rd(2'b00, v); chk("t6_rst_data", v, 8'h00);
    send(8'h5A, 1'b1);
    rd(2'b00, v); chk("t6_rst_next", v, 8'h5A);

    do_reset();
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 4);
      if (op <= 1) begin
        logic [7:0] ch;
        logic stp;
        ch = 8'($urandom);
        stp = ($urandom_range(0, 7) != 0);
        send(ch, stp);
        if (!stp) m_ferr = 1;
        else if (mq.size() == 4) m_ovr = 1;
        else mq.push_back(ch);
        chk("rnd_rda", rda_w, mq.size() != 0);
      end else if (op == 2) begin
        rd(2'b00, v);
        e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        chk("rnd_data", v, e);
      end else if (op == 3) begin
        rd(2'b01, v);
        chk("rnd_stat", v, model_stat());
        m_ovr = 0; m_ferr = 0; m_perr = 0;
      end else begin
        wr_or_unmapped(1'($urandom));
        chk("rnd_err", err_w, m_ovr | m_ferr | m_perr);
      end
    end
    while (mq.size() != 0) begin
      rd(2'b00, v);
      e = mq.pop_front();
      chk("rnd_drain", v, e);
    end
    rd(2'b01, v);
    chk("rnd_final_stat", v, model_stat());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
